// File: rtl/relm_uart_io_pkg.sv
// Shared definitions for the ReLM buffered UART: bus bit positions, FSM
// state encodings and the default baud divider for the 50 MHz board clock.
package relm_uart_io_pkg;

  // 50 MHz / 115200 baud
  localparam int BAUD_DIV_50MHZ = 434;

  // Bit positions on the push/pop buses, expressed as offsets below WD
  localparam int STB_OFS  = 0;  // push/pop strobe, RX-empty retry flag
  localparam int OVR_OFS  = 1;  // overrun sticky flag on pop_q
  localparam int FERR_OFS = 2;  // framing-error sticky flag on pop_q
  localparam int CLR_OFS  = 1;  // clear-error request on pop_d

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // Absolute bit index on a WD+1 bit bus for a given offset
  function automatic int bus_bit(input int wd, input int ofs);
    return wd - ofs;
  endfunction

endpackage

// File: rtl/relm_uart_fifo.sv
// Show-ahead byte FIFO with 2**WAF entries. Pointers carry an extra wrap bit
// so full and empty fall out of a plain compare; both flags are registered.
// A write while full is accepted only when a read retires the head on the
// same edge, so the count stays full without losing the new entry.
module relm_uart_fifo #(
  parameter int WAF = 4,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] d,
  input  logic          re,
  output logic [DW-1:0] q,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** WAF;

  logic [DW-1:0] mem_q [DEPTH];
  logic [WAF:0]  wp_q, wp_d;
  logic [WAF:0]  rp_q, rp_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_en, rd_en;

  // Next pointers and flags from the qualified read/write requests
  always_comb begin
    rd_en   = re && !empty_q;
    wr_en   = we && (!full_q || rd_en);
    wp_d    = wp_q + {{WAF{1'b0}}, wr_en};
    rp_d    = rp_q + {{WAF{1'b0}}, rd_en};
    empty_d = (wp_d == rp_d);
    full_d  = (wp_d[WAF] != rp_d[WAF]) && (wp_d[WAF-1:0] == rp_d[WAF-1:0]);
  end

  // Pointer and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q[WAF-1:0]] <= d;
  end

  assign q     = mem_q[rp_q[WAF-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/relm_uart_io.sv
// Buffered UART attached to the ReLM push/pop I/O ports. Pushed bytes queue
// in a TX FIFO and are serialised 8N1; received frames queue in an RX FIFO
// that the processor drains through the pop port, with sticky overrun and
// framing-error flags.
//
// TX FSM  state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (0) for BAUD_DIV clocks
//   DATA  | 8 data bits, LSB first, BAUD_DIV clocks each
//   STOP  | stop bit (1); chains straight into START if more bytes wait
//
// RX FSM  state | meaning
//   IDLE  | waiting for the synchronized line to drop
//   START | half-bit wait, then confirm the start bit (reject glitches)
//   DATA  | sample 8 bits at mid-bit, LSB first
//   STOP  | check stop bit; store the byte or flag a framing error
//   BREAK | line held low after a bad stop bit; wait for it to go high
module relm_uart_io
  import relm_uart_io_pkg::*;
#(
  parameter int WD       = 32,
  parameter int BAUD_DIV = BAUD_DIV_50MHZ,
  parameter int WAF      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic        uart_in,
  output logic        uart_out
);

  localparam int STB  = bus_bit(WD, STB_OFS);
  localparam int OVR  = bus_bit(WD, OVR_OFS);
  localparam int FERR = bus_bit(WD, FERR_OFS);
  localparam int CLR  = bus_bit(WD, CLR_OFS);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] TX_RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] RX_FULL   = CW'(BAUD_DIV);
  localparam logic [CW-1:0] RX_HALF   = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Only the strobe/clear bits and the TX byte are meaningful on the buses
  logic unused_bits;
  assign unused_bits = ^{push_d[WD-1:8], pop_d[WD-2:0]};

  // ---------------------------------------------------------------- FIFOs
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_we, rx_full, rx_empty;
  logic [7:0] rx_head;

  // Acceptance uses the registered full flag only, so a push coinciding with
  // a TX pop on a full FIFO is still refused.
  assign tx_push = push_d[STB] && !tx_full;

  relm_uart_fifo #(.WAF(WAF), .DW(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (tx_push),
    .d     (push_d[7:0]),
    .re    (tx_pop),
    .q     (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  logic [7:0] rx_sh_q, rx_sh_d;

  relm_uart_fifo #(.WAF(WAF), .DW(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (rx_we),
    .d     (rx_sh_q),
    .re    (pop_d[STB]),
    .q     (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign push_retry = tx_full;

  // -------------------------------------------------------------- TX FSM
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          uart_out_q, uart_out_d;
  logic          tx_expire;

  // TX next state; the line register follows the current state one clock later
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    tx_expire  = (tx_cnt_q == '0);
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_cnt_d   = TX_RELOAD;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_expire) begin
          tx_cnt_d   = TX_RELOAD;
          tx_idx_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_expire) begin
          tx_cnt_d = TX_RELOAD;
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_idx_d   = tx_idx_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_expire) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_cnt_d   = TX_RELOAD;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    unique case (tx_state_q)
      TX_START: uart_out_d = 1'b0;
      TX_DATA:  uart_out_d = tx_sh_q[tx_idx_q];
      default:  uart_out_d = 1'b1;
    endcase
  end

  // TX state, timer and line registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      uart_out_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      uart_out_q <= uart_out_d;
    end
  end

  assign uart_out = uart_out_q;

  // -------------------------------------------------------------- RX FSM
  logic          rx_meta_q, rx_sync_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic          rx_expire;
  logic          ovr_set, ferr_set;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;

  // Two-stage synchronizer; idles high like the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next state, FIFO write and error-flag updates
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_we      = 1'b0;
    ovr_set    = 1'b0;
    ferr_set   = 1'b0;
    rx_expire  = (rx_cnt_q == CNT_ONE);
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = RX_HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = RX_FULL;
            rx_idx_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_expire) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = RX_FULL;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_we      = 1'b1;
            // a full FIFO only makes room if the processor pops on this edge
            ovr_set    = rx_full && !pop_d[STB];
            rx_state_d = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // a new error on the same edge as a clear request takes priority
    ovr_d  = ovr_set  || (ovr_q  && !pop_d[CLR]);
    ferr_d = ferr_set || (ferr_q && !pop_d[CLR]);
  end

  // RX state, timer, shift and sticky-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Pop-port read word; the data field reads zero while the FIFO is empty
  always_comb begin
    pop_q       = '0;
    pop_q[STB]  = rx_empty;
    pop_q[OVR]  = ovr_q;
    pop_q[FERR] = ferr_q;
    pop_q[7:0]  = rx_empty ? 8'h00 : rx_head;
  end

endmodule

// File: tb/tb_relm_uart_io.sv
// Bench for relm_uart_io with BAUD_DIV=8, WAF=2 (4-entry FIFOs).
module tb_relm_uart_io;

  localparam int WD    = 32;
  localparam int BD    = 8;
  localparam int WAF   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [WD:0] push_d = '0;
  logic [WD:0] pop_d  = '0;
  logic        uart_in = 1'b1;
  logic        push_retry;
  logic [WD:0] pop_q;
  logic        uart_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relm_uart_io #(.WD(WD), .BAUD_DIV(BD), .WAF(WAF)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_d     (push_d),
    .push_retry (push_retry),
    .pop_d      (pop_d),
    .pop_q      (pop_q),
    .uart_in    (uart_in),
    .uart_out   (uart_out)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WD:0] rx_word(input logic empty, input logic ovr,
                                          input logic ferr, input logic [7:0] head);
    logic [WD:0] w;
    w = '0;
    w[WD] = empty;
    w[WD-1] = ovr;
    w[WD-2] = ferr;
    w[7:0] = head;
    return w;
  endfunction

  // Decode one frame from uart_out: returns byte and the cycle the start bit appeared
  task automatic get_tx_frame(output logic [7:0] b, output int t0);
    int n;
    n = 0;
    b = '0;
    t0 = -1;
    @(negedge clk);
    while (uart_out !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (uart_out !== 1'b0) begin
      check("tx_frame_timeout", uart_out, 0);
      return;
    end
    t0 = cyc;
    repeat (BD/2) @(negedge clk);
    check("tx_start_bit", uart_out, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = uart_out;
    end
    repeat (BD) @(negedge clk);
    check("tx_stop_bit", uart_out, 1);
  endtask

  // Drive one 8N1 frame on uart_in; a bad stop bit is followed by a long low break
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_in = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_in = stop;
    repeat (BD) @(negedge clk);
    if (!stop) begin
      repeat (3*BD) @(negedge clk);
      uart_in = 1'b1;
      repeat (BD) @(negedge clk);
    end
    uart_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Assert pop_d bits for exactly the edge on which the stop bit is evaluated
  task automatic strobe_at_write(input logic [WD:0] m);
    @(negedge clk);
    repeat (78) @(posedge clk);
    #1 pop_d = m;
    @(posedge clk);
    #1 pop_d = '0;
  endtask

  task automatic pulse(input int bitn);
    @(negedge clk);
    pop_d[bitn] = 1'b1;
    @(negedge clk);
    pop_d[bitn] = 1'b0;
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_in = 1'b0;
    repeat (3) @(negedge clk);
    uart_in = 1'b1;
    repeat (2*BD) @(negedge clk);
  endtask

  // act: 0 good frame, 1 bad-stop frame, 2 pop, 3 clear errors, 4 glitch
  task automatic do_act(input int act, input logic [7:0] d);
    case (act)
      0: send_frame(d, 1'b1);
      1: send_frame(d, 1'b0);
      2: pulse(WD);
      3: pulse(WD-1);
      default: glitch();
    endcase
  endtask

  typedef struct {
    int         act;
    logic [7:0] data;
    logic       exp_empty;
    logic       exp_ovr;
    logic       exp_ferr;
    logic [7:0] exp_head;
  } rx_vec_t;

  rx_vec_t vt[18];

  // Reference model for the randomized RX phase
  logic [7:0] mq[$];
  logic       m_ovr, m_ferr;

  function automatic logic [WD:0] model_word();
    return rx_word(mq.size() == 0, m_ovr, m_ferr, (mq.size() > 0) ? mq[0] : 8'h00);
  endfunction

  initial begin
    logic [7:0]  b;
    int          t0, e, zeros, np;
    logic [7:0]  tb_bytes[6];
    logic [7:0]  rb[5];
    int          rt[5];
    logic [WD:0] m;
    logic [7:0]  d;
    logic        st;

    vt[0]  = '{0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[1]  = '{2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[3]  = '{0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[4]  = '{0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[5]  = '{0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[6]  = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h11};
    vt[7]  = '{2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22};
    vt[8]  = '{3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[9]  = '{4, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[10] = '{1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h22};
    vt[11] = '{0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h22};
    vt[12] = '{2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};
    vt[13] = '{2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44};
    vt[14] = '{2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77};
    vt[15] = '{2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[16] = '{2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[17] = '{3, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_uart_out", uart_out, 1);
    check("rst_push_retry", push_retry, 0);
    check("rst_pop_q", pop_q, rx_word(1'b1, 1'b0, 1'b0, 8'h00));
    rst = 1'b0;

    // Reset in the middle of a TX frame takes effect without a clock edge
    @(negedge clk);
    push_d = '0; push_d[WD] = 1'b1; push_d[7:0] = 8'h00;
    @(negedge clk);
    push_d = '0;
    repeat (30) @(negedge clk);
    check("tx_mid_frame_low", uart_out, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_uart_out", uart_out, 1);
    check("async_rst_push_retry", push_retry, 0);
    check("async_rst_pop_q", pop_q, rx_word(1'b1, 1'b0, 1'b0, 8'h00));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", uart_out, 1);

    // Single push into an idle transmitter: start bit two edges after acceptance
    e = 0;
    fork
      get_tx_frame(b, t0);
      begin
        @(negedge clk);
        push_d = '0; push_d[WD] = 1'b1; push_d[7:0] = 8'h55;
        @(posedge clk);
        #1 e = cyc;
        push_d = '0;
      end
    join
    check("tx_latency", t0 - e, 2);
    check("tx_byte_55", b, 8'h55);

    // Back-to-back pushes while busy: 4 queue up, the 5th is refused
    for (int k = 0; k < 6; k++) tb_bytes[k] = {5'($urandom), 3'(k)};
    fork
      begin
        for (int k = 0; k < 5; k++) get_tx_frame(rb[k], rt[k]);
      end
      begin
        @(negedge clk);
        push_d = '0; push_d[WD] = 1'b1; push_d[7:0] = tb_bytes[0];
        @(posedge clk);
        #1 push_d = '0;
        repeat (2) @(negedge clk);
        for (int k = 1; k < 6; k++) begin
          if (k == 4) check("tx_retry_3_queued", push_retry, 0);
          if (k == 5) check("tx_retry_4_queued", push_retry, 1);
          push_d = '0; push_d[WD] = 1'b1; push_d[7:0] = tb_bytes[k];
          @(negedge clk);
        end
        push_d = '0;
        check("tx_full_hold", push_retry, 1);
      end
    join
    for (int k = 0; k < 5; k++) check($sformatf("tx_b2b_byte%0d", k), rb[k], tb_bytes[k]);
    for (int k = 1; k < 5; k++) check($sformatf("tx_b2b_gap%0d", k), rt[k] - rt[k-1], 10*BD);
    zeros = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (uart_out !== 1'b1) zeros++;
    end
    check("tx_no_extra_frame", zeros, 0);
    check("tx_retry_drained", push_retry, 0);

    // RX vector table
    for (int i = 0; i < 18; i++) begin
      do_act(vt[i].act, vt[i].data);
      check($sformatf("rx_vec%0d", i), pop_q,
            rx_word(vt[i].exp_empty, vt[i].exp_ovr, vt[i].exp_ferr, vt[i].exp_head));
    end

    // Full FIFO: write and pop on the same edge, then clear against a new overrun
    for (int k = 1; k <= 4; k++) send_frame(8'h80 + 8'(k), 1'b1);
    check("rx_fill4", pop_q, rx_word(1'b0, 1'b0, 1'b0, 8'h81));
    m = '0; m[WD] = 1'b1;
    fork
      send_frame(8'h85, 1'b1);
      strobe_at_write(m);
    join
    check("rx_full_write_pop", pop_q, rx_word(1'b0, 1'b0, 1'b0, 8'h82));
    m = '0; m[WD-1] = 1'b1;
    fork
      send_frame(8'h86, 1'b1);
      strobe_at_write(m);
    join
    check("rx_set_beats_clear", pop_q, rx_word(1'b0, 1'b1, 1'b0, 8'h82));
    pulse(WD);
    check("rx_drain_83", pop_q, rx_word(1'b0, 1'b1, 1'b0, 8'h83));
    pulse(WD);
    check("rx_drain_84", pop_q, rx_word(1'b0, 1'b1, 1'b0, 8'h84));
    pulse(WD);
    check("rx_drain_85", pop_q, rx_word(1'b0, 1'b1, 1'b0, 8'h85));
    pulse(WD);
    check("rx_drain_empty", pop_q, rx_word(1'b1, 1'b1, 1'b0, 8'h00));
    pulse(WD-1);
    check("rx_drain_clear", pop_q, rx_word(1'b1, 1'b0, 1'b0, 8'h00));

    // Randomized RX traffic against a queue model
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    for (int it = 0; it < 12; it++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, st);
      if (st) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovr = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      check($sformatf("rnd_frame%0d", it), pop_q, model_word());
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        pulse(WD);
        if (mq.size() > 0) void'(mq.pop_front());
        check($sformatf("rnd_pop%0d", it), pop_q, model_word());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse(WD-1);
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check($sformatf("rnd_clear%0d", it), pop_q, model_word());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relm_uart_io.md
Name: relm_uart_io

Overview:
- Buffered UART peripheral for the ReLM processor's push/pop I/O ports.
- Consumes the processor's push port for transmit: bytes go through a TX FIFO to the serial line.
- Feeds the processor's pop port for receive: bytes go from the serial line through an RX FIFO to the processor.
- Replaces unbuffered single-byte UART handling, so bursts of UART traffic do not stall the core or drop bytes.

Parameters:
- WD, 32, processor data width; push/pop buses are WD+1 bits (bit WD = strobe/retry flag).
- BAUD_DIV, 434, clocks per bit (50 MHz / 115200); minimum 4.
- WAF, 4, log2 FIFO depth; TX and RX FIFOs each hold 2**WAF entries.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- push_d, input, WD+1, processor push bus; [WD] = push strobe, [7:0] = TX byte.
- push_retry, output, 1, high when TX FIFO full; a push strobed while high is not accepted.
- pop_d, input, WD+1, processor pop bus; [WD] = pop strobe, [WD-1] = clear-error request.
- pop_q, output, WD+1, [WD] = RX empty (retry), [WD-1] = overrun sticky, [WD-2] = framing-error sticky, [7:0] = RX head byte, other bits 0.
- uart_in, input, 1, serial RX line (asynchronous).
- uart_out, output, 1, serial TX line.

Behaviour:
- Reset (async, applied immediately): uart_out=1; both FIFOs empty; push_retry=0; pop_q[WD]=1; sticky flags 0; pop_q[7:0]=0; both FSMs idle.
- All outputs are registered or driven from registered state; no combinational path from push_d/pop_d to push_retry/pop_q.
- TX push: accepted at an edge iff push_d[WD]=1 and the full flag is 0 at that edge. If not accepted, it is ignored with no side effects; the processor retries.
- TX FSM states: IDLE, START, DATA, STOP; a bit counter of 0..BAUD_DIV-1 and a 3-bit index.
  - IDLE: if TX FIFO non-empty, pop the head and enter START.
  - Each state lasts exactly BAUD_DIV clocks.
  - START drives 0; DATA drives the 8 bits LSB first; STOP drives 1.
  - After STOP, re-evaluate IDLE with no extra idle clock, so back-to-back frames are exactly 10*BAUD_DIV clocks.
  - Push accepted at edge E into an empty FIFO with TX idle: uart_out=0 from edge E+2.
- RX input uses a 2-FF synchronizer; all decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: synchronized line 0 → START; counter loads BAUD_DIV/2.
  - START: at expiry, if line=1 (glitch) → IDLE with nothing written; else → DATA with counter BAUD_DIV.
  - DATA: sample at each expiry, shift in LSB first; after 8 samples → STOP.
  - STOP at expiry, line=1: write the byte to the RX FIFO. If the FIFO is full and not popped that edge, drop the byte and set overrun. Then → IDLE.
  - STOP at expiry, line=0: set framing error, discard the byte, → BREAK.
  - BREAK: wait for line=1, then → IDLE.
- RX pop: pop_d[WD]=1 with RX non-empty advances the head. pop_q shows the new head (or empty) from the next edge. A pop while empty is ignored.
- Simultaneous RX write and pop on a full FIFO: both take effect; the count stays full; no overrun.
- Simultaneous TX push and TX FSM pop on a full FIFO: the push is still rejected, because the full flag is sampled before the edge.
- Clear errors: pop_d[WD-1]=1 clears both sticky flags at that edge, independent of pop_d[WD]. If an error sets on the same edge, set wins.
- FIFOs are show-ahead: the head is visible on the output while non-empty. Pointers are WAF+1 bits; full/empty come from pointer compare with wrap bit, registered.

Decomposition:
- Shared include (relm_uart_defs): bit-index constants for the strobe, overrun, ferr and clear bits relative to WD; FSM state encodings; the default BAUD_DIV for the 50 MHz board clock.
- One sub-module: relm_uart_fifo.
  - Parameters: WAF, 8-bit width.
  - Ports: clk/rst, write (we/d), read (re/q), full, empty.
  - Instantiated twice.
- The baud counter and both FSMs stay in the top module.

Test Plan (BAUD_DIV=8, WAF=2 unless stated):
- Reset mid-TX-frame → uart_out=1 immediately; push_retry=0; pop_q=0x100000000 (bit WD set, rest 0).
- Push 0x55 at edge E → uart_out=0 at E+2. Bits sampled every 8 clocks are 1,0,1,0,1,0,1,0, then stop=1. Total frame 80 clocks.
- Push 5 bytes back-to-back while TX busy:
  - FIFO fills with 4 entries and push_retry=1; the 5th push is not accepted.
  - Frames are contiguous, 80 clocks each, data 4 distinct bytes in order.
- Drive frame 0xA5 on uart_in → pop_q[7:0]=0xA5 and pop_q[WD]=0 after the stop sample. Pop → pop_q[WD]=1 next cycle.
- Send 5 frames without popping → the first 4 are retained in order and overrun=1. Assert pop_d[WD-1] → overrun=0.
- uart_in low for 3 clocks (glitch) → no FIFO write.
- Frame with stop=0 → framing error=1 and no write. FSM stays in BREAK until the line returns high, then the next valid frame is received.
